rs_enc_stats_log_ctrl: RTL and testbench

Controller for the RS-encode statistics log. It keeps the free-running timestamp, bytes-sent and requests-done counters, and snapshots them once per record period into a single-port stats RAM that it instantiates internally. It also serves indexed read requests from the stats NoC front-end and returns one 192-bit record per request. It sits between the encoder datapath, which supplies the counter increments, and the stats request/response flit converter.

---
 rtl/rs_enc_stats_log_ctrl_if.sv | 15 +
 rtl/rs_enc_stats_log_ctrl.sv | 100 ++++++++++
 tb/tb_rs_enc_stats_log_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rs_enc_stats_log_ctrl_if.sv
// rs_enc_stats_log_ctrl_if: indexed stats read request/response channel
interface rs_enc_stats_log_ctrl_if #(
  parameter int CLIENT_ADDR_W = 16,
  parameter int STAT_W = 64
);
  logic req_val;
  logic req_rdy;
  logic [CLIENT_ADDR_W-1:0] req_addr;
  logic resp_val;
  logic resp_rdy;
  logic [CLIENT_ADDR_W-1:0] resp_addr;
  logic [3*STAT_W-1:0] resp_data;
  modport master(output req_val, req_addr, resp_rdy, input req_rdy, resp_val, resp_addr, resp_data);
  modport slave(input req_val, req_addr, resp_rdy, output req_rdy, resp_val, resp_addr, resp_data);
endinterface

// File: rtl/rs_enc_stats_log_ctrl.sv
// rs_enc_stats_log_ctrl: stats counters, periodic snapshot log in a single-port RAM, indexed readback
// Define RS_ENC_STATS_WRAP_EN to make the log circular; otherwise logging stops when full.
module rs_enc_stats_log_ctrl #(
  parameter int RECORD_PERIOD = 125000000,
  parameter int STATS_DEPTH_LOG2 = 8,
  parameter int CLIENT_ADDR_W = 16,
  parameter int STAT_W = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_req_done,
  input  logic enc_bytes_val,
  input  logic [15:0] enc_bytes,
  rs_enc_stats_log_ctrl_if.slave bus,
  output logic [STATS_DEPTH_LOG2:0] num_records,
  output logic log_full
);
  localparam int DEPTH = 1 << STATS_DEPTH_LOG2;
  localparam int PW = $clog2(RECORD_PERIOD);
  localparam int RW = 3 * STAT_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [STAT_W-1:0] timestamp, bytes_sent, reqs_done;
  logic [PW-1:0] per_cnt;
  logic tick, snap_go, snap_pend;
  logic [RW-1:0] snap_reg, ram_q;
  logic [RW-1:0] mem [DEPTH];
  logic [STATS_DEPTH_LOG2-1:0] wr_ptr, ram_addr;
  logic [CLIENT_ADDR_W-1:0] addr_q;
  logic in_rng, rd_ok, ram_re;
  assign tick = per_cnt == PW'(RECORD_PERIOD - 1);
  assign log_full = num_records[STATS_DEPTH_LOG2];
`ifdef RS_ENC_STATS_WRAP_EN
  assign snap_go = tick;
`else
  assign snap_go = tick && !log_full;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timestamp <= '0;
      bytes_sent <= '0;
      reqs_done <= '0;
      per_cnt <= '0;
    end else begin
      timestamp <= timestamp + 1'b1;
      if (enc_bytes_val) bytes_sent <= bytes_sent + STAT_W'(enc_bytes);
      if (enc_req_done) reqs_done <= reqs_done + 1'b1;
      per_cnt <= tick ? '0 : per_cnt + 1'b1;
    end
  // Ticks are at least 4 cycles apart, so a snapshot always drains before the next one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap_reg <= '0;
      snap_pend <= 1'b0;
      wr_ptr <= '0;
      num_records <= '0;
    end else if (snap_go) begin
      snap_reg <= {timestamp, bytes_sent, reqs_done};
      snap_pend <= 1'b1;
    end else if (snap_pend) begin
      snap_pend <= 1'b0;
      wr_ptr <= wr_ptr + 1'b1;
      if (!log_full) num_records <= num_records + 1'b1;
    end
  assign ram_addr = snap_pend ? wr_ptr : addr_q[STATS_DEPTH_LOG2-1:0];
  always_ff @(posedge clk)
    if (snap_pend) mem[ram_addr] <= snap_reg;
    else if (ram_re) ram_q <= mem[ram_addr];
  assign in_rng = addr_q < CLIENT_ADDR_W'(num_records);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.req_val ? ISSUE : IDLE;
      ISSUE: state_nxt = snap_pend ? ISSUE : WAIT;
      WAIT: state_nxt = RESP;
      RESP: state_nxt = bus.resp_rdy ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_rdy = state == IDLE;
    bus.resp_val = state == RESP;
    ram_re = state == ISSUE && !snap_pend && in_rng;
  end
  // rd_ok carries the range decision of the issuing cycle into WAIT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      rd_ok <= 1'b0;
      bus.resp_data <= '0;
    end else begin
      if (bus.req_rdy && bus.req_val) addr_q <= bus.req_addr;
      rd_ok <= ram_re;
      if (state == WAIT) bus.resp_data <= rd_ok ? ram_q : '0;
    end
  assign bus.resp_addr = addr_q;
endmodule

// File: tb/tb_rs_enc_stats_log_ctrl.sv
// tb_rs_enc_stats_log_ctrl: directed checks of counters, snapshot log, read path and reset
module tb_rs_enc_stats_log_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic enc_req_done, enc_bytes_val;
  logic [15:0] enc_bytes;
  logic [2:0] num_records;
  logic log_full;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [191:0] held;
  rs_enc_stats_log_ctrl_if bus();
  rs_enc_stats_log_ctrl #(.RECORD_PERIOD(8), .STATS_DEPTH_LOG2(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enc_req_done(enc_req_done),
    .enc_bytes_val(enc_bytes_val),
    .enc_bytes(enc_bytes),
    .bus(bus),
    .num_records(num_records),
    .log_full(log_full)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [191:0] rec(input logic [63:0] t, input logic [63:0] b, input logic [63:0] r);
    return {t, b, r};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask
  // Handshakes in the current cycle and returns in the first resp_val cycle.
  task automatic rd(input logic [15:0] a, input int lat, input logic [191:0] exp);
    int n;
    check("req_rdy_idle", 192'(bus.req_rdy), 192'(1));
    bus.req_val = 1'b1;
    bus.req_addr = a;
    step();
    bus.req_val = 1'b0;
    bus.req_addr = '0;
    n = 1;
    check("req_rdy_busy", 192'(bus.req_rdy), 192'(0));
    while (!bus.resp_val && n < 10) begin
      step();
      n++;
    end
    check("rd_lat", 192'(n), 192'(lat));
    check("resp_addr", 192'(bus.resp_addr), 192'(a));
    check("resp_data", bus.resp_data, exp);
  endtask
  initial begin
    rst_n = 1'b0;
    enc_req_done = 1'b0;
    enc_bytes_val = 1'b0;
    enc_bytes = '0;
    bus.req_val = 1'b0;
    bus.req_addr = '0;
    bus.resp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", 192'(bus.req_rdy), 192'(1));
    check("rst_resp_val", 192'(bus.resp_val), 192'(0));
    check("rst_resp_addr", 192'(bus.resp_addr), 192'(0));
    check("rst_resp_data", bus.resp_data, 192'(0));
    check("rst_num", 192'(num_records), 192'(0));
    check("rst_full", 192'(log_full), 192'(0));
    rst_n = 1'b1;
    cyc = 0;
    wait_to(2);
    enc_bytes_val = 1'b1;
    enc_bytes = 16'd100;
    wait_to(5);
    enc_bytes_val = 1'b0;
    enc_bytes = '0;
    wait_to(7);
    enc_req_done = 1'b1;
    step();
    enc_req_done = 1'b0;
    check("num_c8", 192'(num_records), 192'(0));
    step();
    check("num_c9", 192'(num_records), 192'(1));
    check("full_c9", 192'(log_full), 192'(0));
    rd(16'd0, 3, rec(7, 300, 0));
    step();
    check("resp_val_drop", 192'(bus.resp_val), 192'(0));
    rd(16'd5, 3, 192'(0));
    step();
    rd(16'h0100, 3, 192'(0));
    step();
    wait_to(23);
    bus.resp_rdy = 1'b0;
    rd(16'd2, 4, rec(23, 300, 1));
    held = bus.resp_data;
    for (int i = 0; i < 5; i++) begin
      check("hold_val", 192'(bus.resp_val), 192'(1));
      check("hold_rdy", 192'(bus.req_rdy), 192'(0));
      check("hold_data", bus.resp_data, held);
      step();
    end
    bus.resp_rdy = 1'b1;
    step();
    check("num_full", 192'(num_records), 192'(4));
    check("full_set", 192'(log_full), 192'(1));
    rd(16'd1, 3, rec(15, 300, 1));
    step();
    wait_to(48);
`ifdef RS_ENC_STATS_WRAP_EN
    rd(16'd0, 3, rec(39, 300, 1));
`else
    rd(16'd0, 3, rec(7, 300, 0));
`endif
    step();
    rd(16'd3, 3, rec(31, 300, 1));
    step();
    check("num_6p", 192'(num_records), 192'(4));
    check("full_6p", 192'(log_full), 192'(1));
    bus.resp_rdy = 1'b0;
`ifdef RS_ENC_STATS_WRAP_EN
    rd(16'd1, 3, rec(47, 300, 1));
`else
    rd(16'd1, 3, rec(15, 300, 1));
`endif
    rst_n = 1'b0;
    #1;
    check("arst_resp_val", 192'(bus.resp_val), 192'(0));
    check("arst_num", 192'(num_records), 192'(0));
    check("arst_req_rdy", 192'(bus.req_rdy), 192'(1));
    check("arst_resp_data", bus.resp_data, 192'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_rdy = 1'b1;
    cyc = 0;
    rd(16'd0, 3, 192'(0));
    step();
    check("post_rst_num", 192'(num_records), 192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
